adder2_result_collector: RTL
============================

# adder2_result_collector

Downstream stage of the 2-bit registered serial adder (`adder2`). It consumes one 2-bit sum digit per accepted transfer, least-significant digit first, together with the adder's carry. After `DIGITS` digits it presents the assembled `2*DIGITS`-bit word and the final carry to the next consumer under a valid/ready handshake. It turns the adder's digit stream into whole-word results.

## Interface
- `DIGITS`, default 4: digits per result; legal range 2..16.
- `CLK` input 1: single clock; all state updates on its rising edge.
- `Resetn` input 1: reset, synchronous and active-high; sampled on the `CLK` rising edge.
- `in_valid` input 1: `in_s`/`in_c` carry a valid digit.
- `in_ready` output 1: collector can accept a digit this cycle.
- `in_s` input 2: sum digit from `adder2`.
- `in_c` input 1: carry from `adder2` accompanying this digit.
- `out_valid` output 1: `out_sum`/`out_carry` hold a complete result.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output `2*DIGITS`: assembled word; digit k occupies bits `[2k+1:2k]`.
- `out_carry` output 1: `in_c` captured with the last (k = `DIGITS`-1) digit.
- `out_parity` output 1: present only with `ADDER2_COLLECT_PARITY_EN`.

## Operation
- States:
  - COLLECT (reset state): `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Digit transfer = `in_valid && in_ready`. On a transfer, `in_s` is written to the slot selected by the digit index, then the index increments.
- Digit index counter: width `$clog2(DIGITS)`. It counts 0..`DIGITS`-1 and wraps to 0 on the last transfer.
- Last digit (index = `DIGITS`-1) transfer:
  - capture `in_c` into `out_carry`;
  - go to HOLD.
- `in_c` on non-last digits is ignored (intermediate carries are internal to `adder2`).
- HOLD:
  - `out_sum`/`out_carry` are stable until `out_valid && out_ready`;
  - then return to COLLECT and clear the assembly register to 0.
- `in_valid` asserted during HOLD is not a transfer. The digit is not consumed and the upstream must hold it.
- No bypass: a digit offered in the same cycle as the result handshake is not accepted. `in_ready` rises the cycle after.
- Reset values: state=COLLECT, index=0, `out_sum`=0, `out_carry`=0, `out_valid`=0, `in_ready`=1 (from the first cycle after reset), `out_parity`=0.
- Reset mid-collection or mid-HOLD discards partial/held data; the next accepted digit is digit 0.
- Reset has priority over any simultaneous transfer or handshake.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from `out_ready` or `in_valid`.
- `out_valid` rises one cycle after the last digit's transfer edge.
- Minimum result period with `out_ready` held high: `DIGITS`+1 cycles, i.e. `DIGITS` transfers plus one HOLD cycle.
- Throughput during COLLECT: one digit per cycle.

## Configuration
- `ADDER2_COLLECT_PARITY_EN`, when defined:
  - adds the `out_parity` port;
  - `out_parity` = XOR-reduce of `out_sum` and `out_carry`;
  - registered in the same edge that enters HOLD, so it is valid with `out_valid`.
- When undefined: port and logic are absent; all other behaviour is identical.

## Structure
- Shared package `adder2_pkg` holds:
  - `DIGIT_W` = 2;
  - state enum typedef `collect_state_t` {COLLECT, HOLD};
  - shared by `adder2` and this block.
- One sub-module: `adder2_digit_counter`, the wrapping index counter with enable and synchronous clear, exposing `last` (index = `DIGITS`-1).

## Test plan
- Assembly, `DIGITS`=4, `out_ready`=1: digits 01,10,11,00 with `in_c`=0,0,0,1 → one cycle later `out_valid`=1, `out_sum`=8'h39, `out_carry`=1; next cycle `in_ready`=1.
- Backpressure: result pending, `out_ready`=0 for 3 cycles with `in_valid`=1, `in_s`=11 → `out_sum` stable, `in_ready`=0, no digit consumed; after `out_ready`=1, the next result's digit 0 = 11.
- Reset mid-operation: 2 digits accepted, then `Resetn`=1 for one cycle, then digits 11,11,11,11 → `out_sum`=8'hFF.
- Back-to-back: 8 consecutive valid digits 00,01,10,11 repeated, `out_ready`=1 → two results of 8'hE4, each `out_valid` pulse 1 cycle, `in_ready` low exactly 1 cycle per result.
- Parity (macro on): digits 01,00,00,00 with final `in_c`=0 → `out_parity`=1; same digits with final `in_c`=1 → `out_parity`=0.
- Reset priority: assert `Resetn` in the same cycle as the `out_valid && out_ready` handshake → next cycle COLLECT, `out_sum`=0, `out_valid`=0.

Source files
------------

// File: rtl/adder2_pkg.sv
// adder2_pkg
// Definitions shared by the 2-bit serial adder (adder2) and its downstream
// result collector.
//   DIGIT_W          : width of one sum digit produced by adder2.
//   collect_state_t  : collector handshake state (COLLECT / HOLD).
package adder2_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collect_state_t;

endpackage

// File: rtl/adder2_digit_counter.sv
// adder2_digit_counter
// Wrapping digit index counter for the result collector. Counts 0..DIGITS-1
// on each enabled cycle and wraps to 0 after the last digit.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (index -> 0)
//   en   : advance the index (one accepted digit)
//   clr  : synchronous clear of the index
//   idx  : current digit index
//   last : idx equals DIGITS-1
module adder2_digit_counter #(
  parameter int DIGITS = 4,
  localparam int CW    = $clog2(DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] idx,
  output logic          last
);

  assign last = (idx == CW'(DIGITS - 1));

  // Explicit wrap so non-power-of-two DIGITS never walks past the last slot.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : idx + CW'(1);
    end
  end

endmodule

// File: rtl/adder2_result_collector.sv
// adder2_result_collector
// Collects DIGITS consecutive 2-bit sum digits from adder2 (least-significant
// digit first) into one 2*DIGITS-bit word plus the final carry, and hands the
// result to the next stage with a valid/ready handshake.
// Optional feature macro: ADDER2_COLLECT_PARITY_EN adds out_parity, the XOR of
// every bit of out_sum and out_carry, registered together with the result.
// Ports:
//   CLK        : clock, rising edge
//   Resetn     : synchronous reset, active-HIGH despite the name
//   in_valid   : in_s/in_c carry a valid digit
//   in_ready   : collector accepts a digit this cycle (COLLECT state)
//   in_s       : sum digit from adder2
//   in_c       : carry from adder2, kept only with the last digit
//   out_valid  : out_sum/out_carry hold a complete result (HOLD state)
//   out_ready  : consumer accepts the result
//   out_sum    : assembled word, digit k in bits [2k+1:2k]
//   out_carry  : carry captured with the last digit
//   out_parity : (ADDER2_COLLECT_PARITY_EN only) parity of out_sum and out_carry
module adder2_result_collector
  import adder2_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                   CLK,
  input  logic                   Resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIGIT_W-1:0]     in_s,
  input  logic                   in_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_sum,
  output logic                   out_carry
`ifdef ADDER2_COLLECT_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam int CW = $clog2(DIGITS);

  collect_state_t state, state_next;

  logic                      xfer;
  logic                      hs;
  logic                      last;
  logic [CW-1:0]             idx;
  logic [DIGIT_W*DIGITS-1:0] sum_next;

  // Handshake outputs come straight from the state register: no path from
  // in_valid or out_ready, and no same-cycle bypass from HOLD back to COLLECT.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);

  assign xfer = in_valid && in_ready;
  assign hs   = out_valid && out_ready;

  adder2_digit_counter #(
    .DIGITS (DIGITS)
  ) u_digit_counter (
    .clk  (CLK),
    .rst  (Resetn),
    .en   (xfer),
    .clr  (hs),
    .idx  (idx),
    .last (last)
  );

  always_ff @(posedge CLK) begin
    if (Resetn) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (xfer && last) state_next = HOLD;
      HOLD:    if (out_ready)    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Assembly register with the incoming digit dropped into its slot.
  always_comb begin
    sum_next = out_sum;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == CW'(k)) begin
        sum_next[DIGIT_W*k +: DIGIT_W] = in_s;
      end
    end
  end

  // ---- result register stage ----
  // Carries on non-last digits are internal to adder2 and are ignored here.
  always_ff @(posedge CLK) begin
    if (Resetn) begin
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else if (hs) begin
      out_sum <= '0;
    end else if (xfer) begin
      out_sum <= sum_next;
      if (last) begin
        out_carry <= in_c;
      end
    end
  end

`ifdef ADDER2_COLLECT_PARITY_EN
  // Parity is computed from the word being completed so it lands on the same
  // edge that enters HOLD.
  always_ff @(posedge CLK) begin
    if (Resetn) begin
      out_parity <= 1'b0;
    end else if (xfer && last) begin
      out_parity <= ^{sum_next, in_c};
    end
  end
`endif

endmodule
